// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants and state encoding for the serial adder
//
// Purpose: default operand width and FSM state encoding used by serial_add_ctrl.
// Encoding 2'd3 is unused; the controller recovers from it to ST_IDLE.

package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full-adder cell
//
// Purpose: the one shared adder cell time-multiplexed by serial_add_ctrl.
// Ports:
//   a, b  - operand bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer around one full-adder cell
//
// Purpose: adds two WIDTH-bit operands LSB-first, one bit per clock, through a
// single full_adder_bit with a carry flip-flop between bit steps.
// Build option: SERIAL_SUB_EN adds a 'sub' input selecting A-B (cout=1 means A>=B).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - request, accepted in IDLE or DONE
//   a, b, cin     - operands and carry-in, captured on the accepting edge
//   sub           - (SERIAL_SUB_EN only) subtract select, captured on the accepting edge
//   busy          - high while bits are being processed
//   done          - one-cycle pulse when sum/cout have just been updated
//   sum, cout     - result of the last completed operation

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t           state, state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s, fa_co;

`ifdef SERIAL_SUB_EN
  // Two's-complement subtract: A + ~B + 1, with the +1 coming from the carry FF.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 lands at acc[0].
  assign acc_nxt  = WIDTH'({fa_s, acc} >> 1);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= acc_nxt;
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
      // Result registers only move on the final bit so they hold mid-run.
      if (last_bit) begin
        sum  <= acc_nxt;
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed scoreboard bench for serial_add_ctrl

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;
  int pushes     = 0;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s);
    logic [WIDTH:0] t;
    exp_t r;
    if (s) t = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   t = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    r.s = t[WIDTH-1:0];
    r.c = t[WIDTH];
    return r;
  endfunction

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic s);
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = c;
`ifdef SERIAL_SUB_EN
    sub   = s;
`endif
    sb.push_back(model(x, y, c, s));
    pushes++;
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sum", 32'(sum), 32'(mon_e.s));
        check("cout", 32'(cout), 32'(mon_e.c));
      end
    end
  end

  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic s);
    int bc;
    int n;
    @(negedge clk);
    drive(x, y, c, s);
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    n  = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      n++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dc0;
    int n;
    int gap;
    logic stable;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 8'h5A, 8'h33, 1'b0, 1'b0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("cin", 8'h00, 8'h00, 1'b1, 1'b0);

    // Start while busy is ignored.
    dc0 = done_count;
    @(negedge clk);
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busyign_done_seen", 32'(done), 32'd1);
    repeat (20) @(negedge clk);
    check("busyign_one_done", 32'(done_count - dc0), 32'd1);
    check("busyign_idle", 32'(busy), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h7F;
    b = 8'h01;
    sb.push_back(model(8'h7F, 8'h01, 1'b0, 1'b0));
    pushes++;
    n = 0;
    while (!done && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("b2b_first_done", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap", 32'(busy), 32'd1);
    gap    = 1;
    stable = 1'b1;
    while (!done && gap < 40) begin
      if (sum !== 8'h03) stable = 1'b0;
      gap++;
      @(negedge clk);
    end
    check("b2b_gap", 32'(gap), 32'd9);
    check("b2b_sum_stable", 32'(stable), 32'd1);
    @(negedge clk);

    // Reset mid-run aborts immediately.
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_count - dc0), 32'd0);
    run_op("fresh", 8'h0F, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
    run_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1);
    run_op("sub_pos", 8'h07, 8'h05, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_total", 32'(done_count), 32'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. Feeds two WIDTH-bit operands LSB-first through one 1-bit full-adder cell, one bit per clock. A carry flip-flop sits between bit steps. Lets a single full-adder cell perform multi-bit addition at minimal area. Sits between the ui_in/uo_out pin mapping of the top-level wrapper and the shared full-adder cell.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32).
CNT_W, $clog2(WIDTH+1), width of the bit counter (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active low.
start  input  1  request; sampled only when the block can accept it.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
cin  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while an addition is in progress.
done  output  1  single-cycle pulse; result registers updated this cycle.
sum  output  WIDTH  result of the last completed addition.
cout  output  1  carry-out of the last completed addition.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, counter=0, shift registers=0.
- States:
  - IDLE: waiting for work.
  - RUN: processing bits.
  - DONE: completion cycle.
- IDLE or DONE with start=1: capture a, b into shift registers and cin into the carry FF; counter<=0; go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - Feed the full-adder cell with a_sh[0], b_sh[0], carry.
  - carry<=cell cout.
  - Shift the cell sum in at the MSB of acc; shift a_sh and b_sh right by 1.
  - counter++.
- RUN exit: on the edge where counter==WIDTH-1, go to DONE. sum<=final acc; cout<=final carry.
- busy=1 exactly in RUN. done=1 exactly in DONE. Both are registered state decodes.
- Latency: start accepted at edge E0 gives busy high for WIDTH cycles. done is high from E(WIDTH) to E(WIDTH+1). sum and cout are valid from E(WIDTH).
- start while RUN: ignored and not queued. Operand inputs are don't-care.
- Back-to-back: start=1 in DONE is accepted with no IDLE cycle between operations. sum still presents the previous result until the new completion.
- sum and cout hold between completions and never change mid-run.
- Arithmetic: unsigned modulo 2^WIDTH. Carry out of the MSB goes to cout only.
- Reset mid-run: aborts immediately to the reset values. No done pulse; the partial result is discarded.

Optional Feature:
Macro SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on the accepting edge.
  - sub=1: B is inverted into the shift register and the carry FF is loaded with 1. cin is ignored.
  - The result is A-B modulo 2^WIDTH. cout=1 means no borrow (A>=B).
  - sub=0: identical to the undefined build.
- Undefined: no sub port; addition only. The gate count must be identical to a build without the feature logic.

Decomposition:
- Package serial_add_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - Default width constant.
- Sub-module full_adder_bit: purely combinational single-bit cell with ports a, b, ci, s, co.
  - s = a^b^ci.
  - co = (a&b)|(ci&(a^b)).
  - The controller instantiates exactly one. Verification may bind assertions to it.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x33, cin=0, start for 1 cycle -> busy high 8 cycles; done at E8; sum=0x8D, cout=0.
- Carry chain and wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start while busy: start at E0 with a=0x10, b=0x20; start again at E3 with a=0xFF, b=0xFF -> one done only, sum=0x30. No second operation starts.
- Back-to-back: start held high continuously with operands 0x01+0x02, then 0x7F+0x01 -> done at E8 (sum=0x03) and E17 (sum=0x80). No idle gap; sum is stable between the done pulses.
- Reset mid-run: assert rst_n=0 at E4 of 0xAA+0x55 -> busy, done, sum, cout go to 0 without waiting for an edge. After release, a fresh 0x0F+0x01 gives sum=0x10.
- SERIAL_SUB_EN build:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0.
  - a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
